// File: rtl/butterfly_traffic_gen_chk.sv
// Traffic generator and checker for the N-port butterfly network (SERIAL / SHIFT / RANDOM modes).
// Build option: define TGC_BACKPRESSURE_EN to stall net_out_ready pseudo-randomly during RUN/DRAIN.
module butterfly_traffic_gen_chk #(
    parameter int unsigned N       = 8,
    parameter int unsigned PW      = 32,
    parameter int unsigned DW      = PW + $clog2(N),
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [15:0]     num_rounds,
    output logic [N-1:0]    net_in_valid,
    input  logic [N-1:0]    net_in_ready,
    output logic [N*DW-1:0] net_in_data,
    input  logic [N-1:0]    net_out_valid,
    output logic [N-1:0]    net_out_ready,
    input  logic [N*DW-1:0] net_out_data,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [31:0]     sent_cnt,
    output logic [31:0]     rcvd_cnt,
    output logic [15:0]     err_cnt
);
    localparam int unsigned SW = $clog2(N);
    localparam int unsigned QW = PW - SW;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] M_SERIAL = 2'd0;
    localparam logic [1:0] M_SHIFT  = 2'd1;
    localparam logic [1:0] M_RANDOM = 2'd2;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    logic [1:0]    state, state_nxt;
    logic [1:0]    mode_q;
    logic [31:0]   total_q, lane_total_q, issued;
    logic [SW-1:0] cur_src, cur_dst, step_k;
    logic [QW-1:0] seq [N];
    logic [15:0]   lfsr [N];
    logic [31:0]   lane_iss [N];
    logic [PW-1:0] tx_xor, rx_xor;
    logic [TW-1:0] idle_cnt;

    logic [N-1:0]  acc, rcv, issue;
    logic [SW-1:0] dst_c [N];
    logic [31:0]   tx_num, rx_num, err_num, err_sum;
    logic [PW-1:0] tx_x, rx_x;
    logic          start_ok, timeout_c, pass_ok_c;
    logic [N-1:0]  run_ready;

`ifdef TGC_BACKPRESSURE_EN
    logic [15:0] bp_lfsr;

    always_ff @(posedge clk) begin
        if (rst) bp_lfsr <= 16'hACE1;
        else     bp_lfsr <= lfsr_next(bp_lfsr);
    end

    // Two LFSR bits per lane, both set stalls that lane (~25%)
    always_comb begin
        run_ready = '0;
        for (int j = 0; j < N; j++)
            run_ready[j] = ~(bp_lfsr[4'(2 * j)] & bp_lfsr[4'(2 * j + 1)]);
    end
`else
    assign run_ready = '1;
`endif

    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

    // Handshake accounting and header check
    always_comb begin
        acc     = net_in_valid & net_in_ready;
        rcv     = net_out_valid & net_out_ready;
        tx_num  = '0;
        rx_num  = '0;
        err_num = '0;
        tx_x    = tx_xor;
        rx_x    = rx_xor;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                tx_num = tx_num + 32'd1;
                tx_x   = tx_x ^ net_in_data[i*DW +: PW];
            end
            if (rcv[i]) begin
                rx_num = rx_num + 32'd1;
                rx_x   = rx_x ^ net_out_data[i*DW +: PW];
                if (net_out_data[i*DW + PW +: SW] != SW'(i)) err_num = err_num + 32'd1;
            end
        end
        err_sum = 32'(err_cnt) + err_num;
    end

    // Per-lane issue decision and destination per traffic mode
    always_comb begin
        issue = '0;
        for (int i = 0; i < N; i++) begin
            dst_c[i] = cur_dst;
            case (mode_q)
                M_SHIFT: begin
                    dst_c[i] = SW'(i) + step_k;
                    issue[i] = (net_in_valid == '0) && (issued < total_q);
                end
                M_RANDOM: begin
                    dst_c[i] = lfsr[i][SW-1:0];
                    issue[i] = !net_in_valid[i] && (lane_iss[i] < lane_total_q);
                end
                default: issue[i] = (net_in_valid == '0) && (issued < total_q) && (cur_src == SW'(i));
            endcase
            if (state != S_RUN) issue[i] = 1'b0;
        end
    end

    assign timeout_c = (state == S_DRAIN) && (rcv == '0) && (rcvd_cnt != sent_cnt)
                       && (idle_cnt >= TW'(TIMEOUT - 1));
    assign pass_ok_c = (err_cnt == '0) && (rcvd_cnt == sent_cnt) && (tx_xor == rx_xor) && !timeout_c;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
            S_RUN:          if (sent_cnt == total_q) state_nxt = S_DRAIN;
            S_DRAIN:        if ((rcvd_cnt == sent_cnt) || timeout_c) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Generator state, counters and checksums
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= M_SERIAL;
            total_q      <= '0;
            lane_total_q <= '0;
            issued       <= '0;
            cur_src      <= '0;
            cur_dst      <= '0;
            step_k       <= '0;
            net_in_valid <= '0;
            net_in_data  <= '0;
            sent_cnt     <= '0;
            rcvd_cnt     <= '0;
            err_cnt      <= '0;
            tx_xor       <= '0;
            rx_xor       <= '0;
            idle_cnt     <= '0;
            for (int i = 0; i < N; i++) begin
                seq[i]      <= '0;
                lfsr[i]     <= 16'(i + 1);
                lane_iss[i] <= '0;
            end
        end else if (start_ok) begin
            mode_q       <= (mode == M_RANDOM) ? M_RANDOM : ((mode == M_SHIFT) ? M_SHIFT : M_SERIAL);
            total_q      <= 32'(N * N) * 32'(num_rounds);
            lane_total_q <= 32'(N) * 32'(num_rounds);
            issued       <= '0;
            cur_src      <= '0;
            cur_dst      <= '0;
            step_k       <= '0;
            sent_cnt     <= '0;
            rcvd_cnt     <= '0;
            err_cnt      <= '0;
            tx_xor       <= '0;
            rx_xor       <= '0;
            idle_cnt     <= '0;
            for (int i = 0; i < N; i++) begin
                seq[i]      <= '0;
                lfsr[i]     <= 16'(i + 1);
                lane_iss[i] <= '0;
            end
        end else begin
            sent_cnt <= sent_cnt + tx_num;
            rcvd_cnt <= rcvd_cnt + rx_num;
            err_cnt  <= (err_sum > 32'h0000_FFFF) ? 16'hFFFF : err_sum[15:0];
            tx_xor   <= tx_x;
            rx_xor   <= rx_x;

            if (rcv != '0)
                idle_cnt <= '0;
            else if (((state == S_RUN) || (state == S_DRAIN)) && (idle_cnt != TW'(TIMEOUT)))
                idle_cnt <= idle_cnt + TW'(1);

            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    net_in_valid[i] <= 1'b0;
                    seq[i]          <= seq[i] + QW'(1);
                    if (mode_q == M_RANDOM) lfsr[i] <= lfsr_next(lfsr[i]);
                end else if (issue[i]) begin
                    net_in_valid[i]            <= 1'b1;
                    net_in_data[i*DW +: DW]    <= {dst_c[i], SW'(i), seq[i]};
                end
                if (issue[i]) lane_iss[i] <= lane_iss[i] + 32'd1;
            end

            // SERIAL walks dst inner, src outer; SHIFT advances one step per N-lane burst
            if (issue != '0) begin
                if (mode_q == M_SHIFT) begin
                    issued <= issued + 32'(N);
                    step_k <= step_k + SW'(1);
                end else if (mode_q != M_RANDOM) begin
                    issued  <= issued + 32'd1;
                    cur_dst <= cur_dst + SW'(1);
                    if (cur_dst == SW'(N - 1)) cur_src <= cur_src + SW'(1);
                end
            end
        end
    end

    // Registered status outputs follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            net_out_ready <= '0;
        end else begin
            busy <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            done <= (state_nxt == S_DONE);
            if (start_ok)
                pass <= 1'b0;
            else if ((state != S_DONE) && (state_nxt == S_DONE))
                pass <= pass_ok_c;
            case (state_nxt)
                S_IDLE:           net_out_ready <= '0;
                S_RUN, S_DRAIN:   net_out_ready <= run_ready;
                default:          net_out_ready <= '1;
            endcase
        end
    end

endmodule

// File: doc/butterfly_traffic_gen_chk.md
Name: butterfly_traffic_gen_chk

Overview:
Synthesizable traffic generator and checker for the N-port butterfly network. Drives every network input port with a valid/ready stream carrying a destination header, and checks every network output port. Supports three traffic modes, multi-round runs, drain timeout and a pass/fail summary. Instantiated next to the network in system-level and FPGA bring-up builds.

Parameters:
N, 8, port count; power of two, >= 2; SW = $clog2(N) (localparam)
PW, 32, payload width; PW > SW
DW, PW+SW, flit width; header = dst index in bits [DW-1:PW]
TIMEOUT, 1024, idle cycles allowed in DRAIN with no receive before abort

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; accepted only in IDLE or DONE
mode  input  2  0=SERIAL, 1=SHIFT, 2=RANDOM, 3=reserved (treated as SERIAL); sampled at start
num_rounds  input  16  round count, sampled at start
net_in_valid  output  N  per-lane valid to network inputs
net_in_ready  input  N  per-lane ready from network inputs
net_in_data  output  N*DW  lane i at [i*DW +: DW]
net_out_valid  input  N  per-lane valid from network outputs
net_out_ready  output  N  per-lane ready to network outputs
net_out_data  input  N*DW  lane j at [j*DW +: DW]
busy  output  1  high in RUN or DRAIN
done  output  1  high in DONE
pass  output  1  valid while done
sent_cnt  output  32  flits accepted by network
rcvd_cnt  output  32  flits accepted from network
err_cnt  output  16  header mismatches, saturating at 16'hFFFF

Behaviour:
- Reset: FSM=IDLE; net_in_valid=0, net_in_data=0, busy=0, done=0, pass=0, all counters=0, checksums=0, LFSRs=per-lane nonzero seed (lane i seed = i+1). net_out_ready=0 in reset and in IDLE. It is 1 in RUN, DRAIN and DONE, or the pattern given under Optional Feature.
- Reset mid-run aborts immediately to IDLE with the reset values above; no flit is completed.
- FSM: IDLE/DONE --start--> RUN. All counters, checksums and the err_cnt clear on the same edge. DONE holds until start or rst.
- RUN --(all N*N*num_rounds flits accepted)--> DRAIN --(rcvd_cnt==sent_cnt)--> DONE.
- DRAIN --(TIMEOUT consecutive cycles without any receive)--> DONE with pass=0.
- num_rounds=0: RUN -> DRAIN -> DONE in consecutive cycles, sent=rcvd=0, pass=1.
- Payload of lane s: bits [PW-1:PW-SW] = s; bits [PW-SW-1:0] = per-lane sequence number, starting at 0 and +1 per accepted flit, wrapping.
- Handshake: a flit transfers when valid&ready. valid never drops and data never changes until accepted. The next flit of a lane may be presented the cycle after acceptance, giving one flit per lane every 2 cycles max.
- SERIAL: one lane active at a time. Order is src-major (src 0..N-1), dst inner (0..N-1), repeated num_rounds times.
- SHIFT: steps k=0..N-1 per round. In step k every lane s presents dst=(s+k) mod N at the same time. The next step begins only after all N lanes are accepted.
- RANDOM: lanes run independently. Each accepted flit advances a 16-bit Fibonacci LFSR (taps 16,14,13,11); dst = LFSR[SW-1:0]. Each lane sends N*num_rounds flits.
- Checker, each receive on lane j: if header != j, err_cnt+1. Both counters update in the same cycle, and concurrent receives on several lanes add their count. tx_xor ^= every sent payload; rx_xor ^= every received payload.
- pass = (err_cnt==0) && (rcvd_cnt==sent_cnt) && (tx_xor==rx_xor) && no timeout. It is registered on entry to DONE.

Optional Feature:
Macro TGC_BACKPRESSURE_EN. Defined: in RUN/DRAIN, net_out_ready[j] = ~(bp_lfsr[2j % 16] & bp_lfsr[(2j+1) % 16]), about 25% stall. bp_lfsr is a separate 16-bit LFSR, seed 16'hACE1, advancing every cycle. Undefined: net_out_ready = all ones outside IDLE/reset, and no bp_lfsr logic is present.

Test Plan:
- N=8, PW=32, ideal network model, mode=0, rounds=1 -> first flit on lane 0 has header 0, payload 32'h0000_0000. Lane 1's first flit has payload 32'h2000_0000. Done with sent=rcvd=64, err=0, pass=1.
- mode=1, rounds=2 -> all 8 net_in_valid high in the same cycle for each step. Lane 3 step 6 targets dst 1. Sent=rcvd=128, pass=1.
- mode=2, rounds=1, TGC_BACKPRESSURE_EN defined -> each lane sends exactly 8 flits, sent=rcvd=64, pass=1.
- Model corrupts the header of one flit (dst 5 delivered on lane 4), mode=0, rounds=1 -> err_cnt=1, pass=0, rcvd=64.
- Model drops one flit, mode=0, rounds=1 -> DONE reached TIMEOUT cycles after the last receive, rcvd=63, pass=0.
- rst asserted during RUN after 10 flits -> next cycle all outputs at reset values. A new start with rounds=0 -> DONE within 3 cycles, pass=1, counters 0.
